// File: rtl/logic16_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : logic16_arbiter_if
// Purpose  : Request/response bundle between the requesters/consumer and the
//            shared 16-bit logic-unit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface logic16_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [2*NREQ-1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    // Requester and result-consumer side.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic16_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one 16-bit bitwise logic
//            unit (AND/OR/XOR/NAND) among NREQ requesters, with a tagged,
//            held result. Optional macro LOGIC16_ARB_BACK2BACK_EN lets a new
//            request be accepted in the same cycle the result is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module logic16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    logic16_arbiter_if.slave     arb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  id_q;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic [1:0]      op_q;
    logic            rsp_valid_q;
    logic [15:0]     rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            found_d;
    logic [IDW-1:0]  gnt_idx_d;
    logic [IDW:0]    cand_d;
    logic            accept_en_d;
    logic            transfer_d;
    logic [NREQ-1:0] req_ready_d;
    logic [IDW-1:0]  rr_d;
    logic [15:0]     a_sel_d;
    logic [15:0]     b_sel_d;
    logic [1:0]      op_sel_d;
    logic [15:0]     and_lane;
    logic [15:0]     result_d;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        found_d   = 1'b0;
        gnt_idx_d = rr_q;
        cand_d    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_d = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand_d >= (IDW+1)'(NREQ)) begin
                cand_d = cand_d - (IDW+1)'(NREQ);
            end
            if (!found_d && arb.req_valid[cand_d[IDW-1:0]]) begin
                found_d   = 1'b1;
                gnt_idx_d = cand_d[IDW-1:0];
            end
        end
    end

`ifdef LOGIC16_ARB_BACK2BACK_EN
    assign accept_en_d = rst_n &&
                         ((state_q == S_IDLE) ||
                          ((state_q == S_RESP) && arb.rsp_ready));
`else
    assign accept_en_d = rst_n && (state_q == S_IDLE);
`endif

    assign transfer_d = accept_en_d && found_d;

    always_comb begin
        req_ready_d = '0;
        if (transfer_d) begin
            req_ready_d[gnt_idx_d] = 1'b1;
        end
    end

    assign rr_d     = (gnt_idx_d == IDW'(NREQ-1)) ? '0 : gnt_idx_d + 1'b1;
    assign a_sel_d  = arb.req_a[16*gnt_idx_d +: 16];
    assign b_sel_d  = arb.req_b[16*gnt_idx_d +: 16];
    assign op_sel_d = arb.req_op[2*gnt_idx_d +: 2];

    // Shared and16 lane; the NAND result is derived from it as well.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_and16
            assign and_lane[i] = a_q[i] & b_q[i];
        end
    endgenerate

    always_comb begin
        result_d = and_lane;
        case (op_q)
            OP_AND:  result_d = and_lane;
            OP_OR:   result_d = a_q | b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_NAND: result_d = ~and_lane;
            default: result_d = and_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (transfer_d) begin
                a_q  <= a_sel_d;
                b_q  <= b_sel_d;
                op_q <= op_sel_d;
                id_q <= gnt_idx_d;
                rr_q <= rr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (transfer_d) begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= result_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (arb.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        // A same-cycle transfer only exists in back-to-back builds.
                        state_q     <= transfer_d ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.req_ready = req_ready_d;
    assign arb.rsp_valid = rsp_valid_q;
    assign arb.rsp_data  = rsp_data_q;
    assign arb.rsp_id    = rsp_id_q;
    assign arb.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic16_arbiter
// Purpose  : Directed self-checking bench for logic16_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic16_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef LOGIC16_ARB_BACK2BACK_EN
    localparam int EXP_INTERVAL = 2;
`else
    localparam int EXP_INTERVAL = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    logic16_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) arb ();

    logic16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arb.req_valid = '0;
        arb.req_a     = '0;
        arb.req_b     = '0;
        arb.req_op    = '0;
        arb.rsp_ready = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op);
        arb.req_a[16*i +: 16] = a;
        arb.req_b[16*i +: 16] = b;
        arb.req_op[2*i +: 2]  = op;
        arb.req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (arb.req_ready == '0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (arb.req_ready == '0) begin
            total_cnt++;
            $display("FAIL wait_ready: req_ready stayed %b for 20 cycles, required nonzero", arb.req_ready);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        arb.req_valid = 4'b1111;
        rst_n = 1'b0;
        #3;
        total_cnt++;
        if (arb.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", arb.req_ready); else pass_cnt++;
        total_cnt++;
        if (arb.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", arb.rsp_valid); else pass_cnt++;
        total_cnt++;
        if (arb.rsp_data !== 16'h0000) $display("FAIL reset_rsp_data: got %h want 0000", arb.rsp_data); else pass_cnt++;
        total_cnt++;
        if (arb.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", arb.rsp_id); else pass_cnt++;
        total_cnt++;
        if (arb.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", arb.busy); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_basic();
        do_reset();
        set_req(0, 16'hF0F0, 16'h0FF0, 2'b00);
        #1;
        total_cnt++;
        if (arb.req_ready !== 4'b0001) $display("FAIL basic_grant: got %b want 0001", arb.req_ready); else pass_cnt++;
        step();
        arb.req_valid = '0;
        total_cnt++;
        if (arb.busy !== 1'b1 || arb.rsp_valid !== 1'b0)
            $display("FAIL basic_exec: busy=%b rsp_valid=%b want 1/0", arb.busy, arb.rsp_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (arb.rsp_valid !== 1'b1 || arb.rsp_data !== 16'h00F0 || arb.rsp_id !== 2'd0)
            $display("FAIL basic_rsp: valid=%b data=%h id=%0d want 1/00f0/0", arb.rsp_valid, arb.rsp_data, arb.rsp_id);
        else pass_cnt++;
        arb.rsp_ready = 1'b1;
        step();
        total_cnt++;
        if (arb.rsp_valid !== 1'b0 || arb.busy !== 1'b0)
            $display("FAIL basic_drain: valid=%b busy=%b want 0/0", arb.rsp_valid, arb.busy);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_all_four();
        logic [15:0] exp_data [4];
        logic [NREQ-1:0] exp_g;
        exp_data[0] = 16'h5555; exp_data[1] = 16'hFFFF;
        exp_data[2] = 16'h5555; exp_data[3] = 16'hAAAA;
        do_reset();
        set_req(0, 16'hAAAA, 16'hFFFF, 2'b10);
        set_req(1, 16'hAAAA, 16'hFFFF, 2'b01);
        set_req(2, 16'hAAAA, 16'hFFFF, 2'b11);
        set_req(3, 16'hAAAA, 16'hFFFF, 2'b00);
        arb.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            exp_g = 4'b0001 << k;
            total_cnt++;
            if (arb.req_ready !== exp_g) $display("FAIL all4_grant%0d: got %b want %b", k, arb.req_ready, exp_g); else pass_cnt++;
            step();
            step();
            total_cnt++;
            if (arb.rsp_valid !== 1'b1 || arb.rsp_id !== IDW'(k) || arb.rsp_data !== exp_data[k])
                $display("FAIL all4_rsp%0d: valid=%b id=%0d data=%h want 1/%0d/%h",
                         k, arb.rsp_valid, arb.rsp_id, arb.rsp_data, k, exp_data[k]);
            else pass_cnt++;
        end
        wait_ready();
        total_cnt++;
        if (arb.req_ready !== 4'b0001) $display("FAIL all4_wrap: got %b want 0001", arb.req_ready); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        set_req(0, 16'h1234, 16'h00FF, 2'b10);
        wait_ready();
        total_cnt++;
        if (arb.req_ready !== 4'b0001) $display("FAIL hold_grant: got %b want 0001", arb.req_ready); else pass_cnt++;
        step();
        arb.req_valid = '0;
        set_req(2, 16'hFFFF, 16'h0F0F, 2'b00);
        step();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (arb.rsp_valid !== 1'b1 || arb.rsp_data !== 16'h12CB || arb.rsp_id !== 2'd0)
                $display("FAIL hold_stable%0d: valid=%b data=%h id=%0d want 1/12cb/0", i, arb.rsp_valid, arb.rsp_data, arb.rsp_id);
            else pass_cnt++;
            total_cnt++;
            if (arb.req_ready !== 4'b0000) $display("FAIL hold_noready%0d: got %b want 0000", i, arb.req_ready); else pass_cnt++;
            step();
        end
        arb.rsp_ready = 1'b1;
        #1;
`ifdef LOGIC16_ARB_BACK2BACK_EN
        total_cnt++;
        if (arb.req_ready !== 4'b0100) $display("FAIL hold_b2b_grant: got %b want 0100", arb.req_ready); else pass_cnt++;
        step();
`else
        total_cnt++;
        if (arb.req_ready !== 4'b0000) $display("FAIL hold_release_ready: got %b want 0000", arb.req_ready); else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (arb.req_ready !== 4'b0100 || arb.rsp_valid !== 1'b0)
            $display("FAIL hold_idle_grant: ready=%b valid=%b want 0100/0", arb.req_ready, arb.rsp_valid);
        else pass_cnt++;
        step();
`endif
        arb.req_valid = '0;
        step();
        total_cnt++;
        if (arb.rsp_valid !== 1'b1 || arb.rsp_data !== 16'h0F0F || arb.rsp_id !== 2'd2)
            $display("FAIL hold_next_rsp: valid=%b data=%h id=%0d want 1/0f0f/2", arb.rsp_valid, arb.rsp_data, arb.rsp_id);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_fairness();
        int exp_id [4];
        logic [NREQ-1:0] exp_g;
        exp_id[0] = 1; exp_id[1] = 3; exp_id[2] = 1; exp_id[3] = 3;
        do_reset();
        arb.rsp_ready = 1'b1;
        set_req(3, 16'h0003, 16'hFFFF, 2'b00);
        set_req(1, 16'h0001, 16'hFFFF, 2'b00);
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            exp_g = 4'b0001 << exp_id[k];
            total_cnt++;
            if (arb.req_ready !== exp_g) $display("FAIL fair_grant%0d: got %b want %b", k, arb.req_ready, exp_g); else pass_cnt++;
            step();
            if (exp_id[k] == 1) arb.req_valid[1] = 1'b0;
            step();
            total_cnt++;
            if (arb.rsp_valid !== 1'b1 || arb.rsp_id !== IDW'(exp_id[k]))
                $display("FAIL fair_rsp%0d: valid=%b id=%0d want 1/%0d", k, arb.rsp_valid, arb.rsp_id, exp_id[k]);
            else pass_cnt++;
            arb.req_valid[1] = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 16'hFFFF, 16'hFFFF, 2'b00);
        wait_ready();
        total_cnt++;
        if (arb.req_ready !== 4'b0100) $display("FAIL rstmid_grant: got %b want 0100", arb.req_ready); else pass_cnt++;
        step();
        arb.req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (arb.rsp_valid !== 1'b0 || arb.busy !== 1'b0)
            $display("FAIL rstmid_async: valid=%b busy=%b want 0/0", arb.rsp_valid, arb.busy);
        else pass_cnt++;
        set_req(0, 16'h00FF, 16'h0F0F, 2'b01);
        set_req(2, 16'hFFFF, 16'hFFFF, 2'b00);
        step();
        total_cnt++;
        if (arb.rsp_valid !== 1'b0 || arb.req_ready !== 4'b0000)
            $display("FAIL rstmid_hold: valid=%b ready=%b want 0/0000", arb.rsp_valid, arb.req_ready);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        #1;
        total_cnt++;
        if (arb.req_ready !== 4'b0001) $display("FAIL rstmid_tie: got %b want 0001", arb.req_ready); else pass_cnt++;
        step();
        arb.req_valid = '0;
        step();
        total_cnt++;
        if (arb.rsp_valid !== 1'b1 || arb.rsp_id !== 2'd0 || arb.rsp_data !== 16'h0FFF)
            $display("FAIL rstmid_rsp: valid=%b id=%0d data=%h want 1/0/0fff", arb.rsp_valid, arb.rsp_id, arb.rsp_data);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int last;
        int nres;
        last = -1;
        nres = 0;
        do_reset();
        arb.rsp_ready = 1'b1;
        set_req(1, 16'h3C3C, 16'hFF00, 2'b10);
        for (int cyc = 0; cyc < 15; cyc++) begin
            step();
            if (arb.rsp_valid === 1'b1) begin
                total_cnt++;
                if (arb.rsp_id !== 2'd1 || arb.rsp_data !== 16'hC33C)
                    $display("FAIL b2b_rsp%0d: id=%0d data=%h want 1/c33c", cyc, arb.rsp_id, arb.rsp_data);
                else pass_cnt++;
                if (last >= 0) begin
                    total_cnt++;
                    if (cyc - last != EXP_INTERVAL)
                        $display("FAIL b2b_interval%0d: got %0d want %0d", cyc, cyc - last, EXP_INTERVAL);
                    else pass_cnt++;
                end
                last = cyc;
                nres++;
            end
        end
        total_cnt++;
        if (nres < 4) $display("FAIL b2b_count: got %0d results want at least 4", nres); else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_all_four();
        test_hold();
        test_fairness();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
